switch_cmd_gen: RTL and testbench
=================================

# switch_cmd_gen

Upstream command stage for the four-digit pattern shifter. Synchronizes and debounces the four slide switches on the divided clock and validates the mode selection. It issues one-cycle shift commands (`cmd`/`cmd_valid`) that the shifter register bank consumes instead of decoding raw switches itself. Illegal switch combinations are flagged and never produce a command.

## Interface
- `DEB_CYC`, 2: consecutive `clk_out` cycles the synchronized switch vector must stay stable before it is accepted; range 1..15.
- `STEP_DIV`, 1: cycles between repeated commands in RUN when auto-repeat is compiled in; range 1..255.
- `clk_out`  in  1  divided system clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `switch`  in  4  raw switches; `[2:0]` mode select (one-hot), `[3]` direction.
- `cmd`  out  3  command code; holds its value between pulses.
- `cmd_valid`  out  1  one-cycle pulse; `cmd` is valid in this cycle.
- `mode_err`  out  1  high while the debounced mode select has more than one bit set.
- `step_cnt`  out  8  number of pulses issued since the last IDLE entry.

## Operation
- Reset values: `cmd`=`CMD_NOP`, `cmd_valid`=0, `mode_err`=0, `step_cnt`=0, state IDLE, sync flops and debounced vector `deb`=4'b0000, counters 0.
- Synchronizer: 2-flop synchronizer on all 4 bits gives `sw_s`.
- Debounce, whole vector:
  - The stability counter clears whenever `sw_s` changes from the previous cycle.
  - When `sw_s`≠`deb` and `sw_s` has been stable for DEB_CYC consecutive edges, `deb` loads `sw_s`.
- Command mapping from `deb`, where `dir`=`deb[3]`:
  - `sel`=001, `dir`=1 → `CMD_SHR_ZERO`; `dir`=0 → `CMD_SHL_ZERO`.
  - `sel`=010, `dir`=1 → `CMD_SHR_KEEP` (digit 0 keeps its value, others shift right); `dir`=0 → `CMD_SHL_ZERO`.
  - `sel`=100, `dir`=1 → `CMD_ROR`; `dir`=0 → `CMD_ROL`.
- FSM states IDLE, RUN, ERR:
  - IDLE, `sel`=000: stay. Outputs `cmd`=NOP, `step_cnt` cleared.
  - IDLE, `sel` one-hot: go to RUN, pulse `cmd_valid` with the mapped command, load the repeat counter with STEP_DIV-1.
  - IDLE, `sel` with ≥2 bits: go to ERR.
  - RUN, `sel` or `dir` changes to another legal combination: new command and pulse on the next edge, repeat counter reloaded.
  - RUN, `sel`=000: go to IDLE, `cmd`=NOP.
  - RUN, ≥2 bits set: go to ERR.
  - ERR: `mode_err`=1, no pulses, `cmd`=NOP. Exit only to IDLE when `sel`=000. A legal one-hot seen in ERR is ignored.
- `step_cnt` increments on every `cmd_valid` pulse and wraps 255→0.
- Simultaneous events in RUN: a combination change and repeat-counter expiry in the same cycle produce one pulse carrying the new command, and the counter is reloaded.
- Reset mid-operation: all state returns to reset values immediately. A pulse in flight is dropped.

## Timing
- Latency from a switch change (set up before edge 1) to `cmd_valid` high: the pulse appears after edge DEB_CYC+3.
  - Edges 1–2: synchronizer.
  - Edges 3..DEB_CYC+2: stability count; `deb` updates at edge DEB_CYC+2.
  - Edge DEB_CYC+3: registered FSM output.
- `cmd_valid` is always exactly one cycle wide. `cmd` changes only on the edge where `cmd_valid` rises, or on entry to IDLE/ERR.
- Auto-repeat, STEP_DIV=N: pulses every N cycles while the combination is unchanged. N=1 gives `cmd_valid` continuously high in RUN, with the count advancing each cycle.
- Glitches shorter than DEB_CYC cycles after synchronization never change `deb`.

## Configuration
- `SWITCH_CMD_AUTOREPEAT_EN` defined: in RUN, the repeat counter reissues the current command every STEP_DIV cycles.
- Not defined: exactly one pulse per legal combination entry or change. The repeat counter and the STEP_DIV logic are absent, and the parameter is accepted but unused.

## Structure
- Shared package `shifter_pkg` holds:
  - The 3-bit command typedef and codes: `CMD_NOP`=0, `CMD_SHL_ZERO`=1, `CMD_SHR_ZERO`=2, `CMD_SHR_KEEP`=3, `CMD_ROL`=4, `CMD_ROR`=5.
  - The FSM state encoding: IDLE=0, RUN=1, ERR=2.
- One sub-module, `sw_debounce`: synchronizer plus whole-vector debounce, parameterized by width and DEB_CYC. The FSM and command mapping live in the top.

## Test plan
- Reset: hold `rst_n`=0 with `switch`=4'b1001 → `cmd`=0, `cmd_valid`=0, `mode_err`=0, `step_cnt`=0. After release with DEB_CYC=2, the first pulse carries `cmd`=2 (`CMD_SHR_ZERO`) after edge 5.
- Glitch rejection, DEB_CYC=2: `switch` 0000→0100 for 1 cycle, then back → no pulse, `deb` stays 0000.
- Direction change in RUN: `switch`=0100, then `switch[3]` goes 0→1 → pulses `cmd`=4, then `cmd`=5. `step_cnt` is 2 in single-shot mode.
- Illegal combination: `switch`=0011 → `mode_err`=1, no pulses. Then 0001 → still ERR. Then 0000 followed by 0001 → exits, `mode_err`=0, pulse `cmd`=1.
- Auto-repeat with macro, STEP_DIV=3: hold 1010 for 10 cycles after the first pulse → pulses with `cmd`=3 every 3 cycles, and `step_cnt` counts 1,2,3,4.
- Wrap and reset mid-run: STEP_DIV=1, auto-repeat on, run 256 pulses → `step_cnt` wraps to 0. Then assert `rst_n` while `cmd_valid`=1 → all outputs 0 within the same cycle.

Source files
------------

// File: rtl/shifter_pkg.sv
// ============================================================================
// Module   : shifter_pkg
// Brief    : Command codes, FSM states and command mapping for the shifter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package shifter_pkg;

    typedef enum logic [2:0] {
        CMD_NOP      = 3'd0,
        CMD_SHL_ZERO = 3'd1,
        CMD_SHR_ZERO = 3'd2,
        CMD_SHR_KEEP = 3'd3,
        CMD_ROL      = 3'd4,
        CMD_ROR      = 3'd5
    } cmd_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        ERR  = 2'd2
    } state_e;

    // sel=010 with dir=0 deliberately shares the plain zero-fill left shift.
    function automatic cmd_e map_cmd(input logic [2:0] sel, input logic dir);
        cmd_e w_cmd;
        case (sel)
            3'b001:  w_cmd = dir ? CMD_SHR_ZERO : CMD_SHL_ZERO;
            3'b010:  w_cmd = dir ? CMD_SHR_KEEP : CMD_SHL_ZERO;
            3'b100:  w_cmd = dir ? CMD_ROR      : CMD_ROL;
            default: w_cmd = CMD_NOP;
        endcase
        return w_cmd;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sw_debounce.sv
// ============================================================================
// Module   : sw_debounce
// Brief    : Two-flop synchronizer plus whole-vector stability debounce.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sw_debounce #(
    parameter int WIDTH   = 4,
    parameter int DEB_CYC = 2
) (
    input  logic             clk_out,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_sw,
    output logic [WIDTH-1:0] o_deb
);

    localparam logic [3:0] c_DEB_CYC = 4'(DEB_CYC);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_deb;
    logic [3:0]       r_stable;
    logic [3:0]       w_stable_n;
    logic             w_load;

    // r_stable counts edges (including this one) at which the synchronized
    // vector has held its current value; a change restarts the count at one.
    always_comb begin
        w_stable_n = r_stable;
        w_load     = 1'b0;
        if (r_sync2 != r_prev) begin
            w_stable_n = 4'd1;
        end else if (r_stable != 4'hF) begin
            w_stable_n = r_stable + 4'd1;
        end
        w_load = (w_stable_n >= c_DEB_CYC) && (r_sync2 != r_deb);
    end

    always_ff @(posedge clk_out or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_prev   <= '0;
            r_deb    <= '0;
            r_stable <= 4'd0;
        end else begin
            r_sync1  <= i_sw;
            r_sync2  <= r_sync1;
            r_prev   <= r_sync2;
            r_stable <= w_stable_n;
            if (w_load) begin
                r_deb <= r_sync2;
            end
        end
    end

    assign o_deb = r_deb;

endmodule

`default_nettype wire

// File: rtl/switch_cmd_gen.sv
// ============================================================================
// Module   : switch_cmd_gen
// Brief    : Debounced switch decode into one-cycle shift commands.
//            SWITCH_CMD_AUTOREPEAT_EN adds periodic reissue in RUN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module switch_cmd_gen #(
    parameter int DEB_CYC  = 2,
    parameter int STEP_DIV = 1
) (
    input  logic       clk_out,
    input  logic       rst_n,
    input  logic [3:0] switch,
    output logic [2:0] cmd,
    output logic       cmd_valid,
    output logic       mode_err,
    output logic [7:0] step_cnt
);

    import shifter_pkg::*;

    if (DEB_CYC < 1 || DEB_CYC > 15) begin : g_bad_deb_cyc
        $error("switch_cmd_gen: DEB_CYC out of range 1..15");
    end
    if (STEP_DIV < 1 || STEP_DIV > 255) begin : g_bad_step_div
        $error("switch_cmd_gen: STEP_DIV out of range 1..255");
    end

    logic [3:0] w_deb;
    logic       w_sel_zero;
    logic       w_sel_legal;
    logic       w_rpt_due;
    logic       w_pulse;
    logic       w_step_clr;
    state_e     w_state_n;
    cmd_e       w_cmd_n;

    state_e     r_state;
    cmd_e       r_cmd;
    logic       r_valid;
    logic [7:0] r_step;
    logic [3:0] r_last;

    sw_debounce #(
        .WIDTH   (4),
        .DEB_CYC (DEB_CYC)
    ) u_deb (
        .clk_out (clk_out),
        .rst_n   (rst_n),
        .i_sw    (switch),
        .o_deb   (w_deb)
    );

    assign w_sel_zero  = (w_deb[2:0] == 3'b000);
    assign w_sel_legal = $onehot(w_deb[2:0]);

`ifdef SWITCH_CMD_AUTOREPEAT_EN
    localparam logic [7:0] c_RPT_LOAD = 8'(STEP_DIV - 1);

    logic [7:0] r_rpt;

    always_ff @(posedge clk_out or negedge rst_n) begin
        if (!rst_n) begin
            r_rpt <= 8'd0;
        end else if (w_pulse) begin
            r_rpt <= c_RPT_LOAD;
        end else if (r_state == RUN && r_rpt != 8'd0) begin
            r_rpt <= r_rpt - 8'd1;
        end
    end

    assign w_rpt_due = (r_rpt == 8'd0);
`else
    assign w_rpt_due = 1'b0;
`endif

    always_comb begin
        w_state_n  = r_state;
        w_cmd_n    = r_cmd;
        w_pulse    = 1'b0;
        w_step_clr = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_sel_zero) begin
                    w_cmd_n    = CMD_NOP;
                    w_step_clr = 1'b1;
                end else if (w_sel_legal) begin
                    w_state_n = RUN;
                    w_pulse   = 1'b1;
                end else begin
                    w_state_n = ERR;
                    w_cmd_n   = CMD_NOP;
                end
            end
            RUN: begin
                if (w_sel_zero) begin
                    w_state_n  = IDLE;
                    w_cmd_n    = CMD_NOP;
                    w_step_clr = 1'b1;
                end else if (!w_sel_legal) begin
                    w_state_n = ERR;
                    w_cmd_n   = CMD_NOP;
                end else if (w_deb != r_last || w_rpt_due) begin
                    // A change coinciding with repeat expiry yields one pulse.
                    w_pulse = 1'b1;
                end
            end
            ERR: begin
                w_cmd_n = CMD_NOP;
                if (w_sel_zero) begin
                    w_state_n  = IDLE;
                    w_step_clr = 1'b1;
                end
            end
            default: begin
                w_state_n = IDLE;
                w_cmd_n   = CMD_NOP;
            end
        endcase
        if (w_pulse) begin
            w_cmd_n = map_cmd(w_deb[2:0], w_deb[3]);
        end
    end

    always_ff @(posedge clk_out or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cmd   <= CMD_NOP;
            r_valid <= 1'b0;
            r_step  <= 8'd0;
            r_last  <= 4'd0;
        end else begin
            r_state <= w_state_n;
            r_cmd   <= w_cmd_n;
            r_valid <= w_pulse;
            if (w_step_clr) begin
                r_step <= 8'd0;
            end else if (w_pulse) begin
                r_step <= r_step + 8'd1;
            end
            if (w_pulse) begin
                r_last <= w_deb;
            end
        end
    end

    assign cmd       = r_cmd;
    assign cmd_valid = r_valid;
    assign mode_err  = (r_state == ERR);
    assign step_cnt  = r_step;

endmodule

`default_nettype wire

// File: tb/tb_switch_cmd_gen.sv
// ============================================================================
// Module   : tb_switch_cmd_gen
// Brief    : Directed and random stimulus against a cycle-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_switch_cmd_gen;

    localparam int DEB  = 2;
    localparam int SDIV = 3;
`ifdef SWITCH_CMD_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic       clk_out = 1'b0;
    logic       rst_n   = 1'b0;
    logic [3:0] switch  = 4'b0000;
    logic [2:0] cmd;
    logic       cmd_valid;
    logic       mode_err;
    logic [7:0] step_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk_out = ~clk_out;

    switch_cmd_gen #(
        .DEB_CYC  (DEB),
        .STEP_DIV (SDIV)
    ) dut (
        .clk_out   (clk_out),
        .rst_n     (rst_n),
        .switch    (switch),
        .cmd       (cmd),
        .cmd_valid (cmd_valid),
        .mode_err  (mode_err),
        .step_cnt  (step_cnt)
    );

    // Reference model: raw-sample history, accepted vector, mode, last pulse.
    logic [3:0] rq[$];
    logic [3:0] m_deb;
    logic [3:0] m_last;
    int         m_state;   // 0 idle, 1 running, 2 error
    logic [2:0] m_cmd;
    logic       m_valid;
    int         m_step;
    int         m_since;
    logic [2:0] tbl [0:5] = '{3'd1, 3'd2, 3'd1, 3'd3, 3'd4, 3'd5};

    task automatic model_reset();
        rq = {};
        repeat (DEB + 2) rq.push_back(4'b0000);
        m_deb = 4'b0000; m_last = 4'b0000; m_state = 0;
        m_cmd = 3'd0; m_valid = 1'b0; m_step = 0; m_since = 0;
    endtask

    task automatic model_edge(input logic [3:0] raw);
        int  pop;
        bit  pulse;
        bit  same;
        pop   = $countones(m_deb[2:0]);
        pulse = 1'b0;
        case (m_state)
            0: begin
                if (pop == 0) begin m_cmd = 3'd0; m_step = 0; end
                else if (pop == 1) begin m_state = 1; pulse = 1'b1; end
                else begin m_state = 2; m_cmd = 3'd0; end
            end
            1: begin
                if (pop == 0) begin m_state = 0; m_cmd = 3'd0; m_step = 0; end
                else if (pop > 1) begin m_state = 2; m_cmd = 3'd0; end
                else if (m_deb != m_last || (AR && m_since + 1 >= SDIV)) pulse = 1'b1;
            end
            default: begin
                if (pop == 0) begin m_state = 0; m_step = 0; end
            end
        endcase
        if (pulse) begin
            m_cmd   = tbl[2 * $clog2(int'(m_deb[2:0])) + int'(m_deb[3])];
            m_last  = m_deb;
            m_step  = (m_step + 1) % 256;
            m_since = 0;
        end else begin
            m_since++;
        end
        m_valid = pulse;
        // Accepted vector: the synchronized value seen on the last DEB edges, if unchanged.
        rq.push_back(raw);
        void'(rq.pop_front());
        same = 1'b1;
        for (int j = 1; j < DEB; j++) if (rq[j] != rq[0]) same = 1'b0;
        if (same) m_deb = rq[0];
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_outputs();
        chk("cmd", {5'd0, cmd}, {5'd0, m_cmd});
        chk("cmd_valid", {7'd0, cmd_valid}, {7'd0, m_valid});
        chk("mode_err", {7'd0, mode_err}, {7'd0, (m_state == 2)});
        chk("step_cnt", step_cnt, m_step[7:0]);
    endtask

    task automatic step(input logic [3:0] sw);
        switch = sw;
        @(posedge clk_out);
        model_edge(sw);
        #1;
        chk_outputs();
    endtask

    initial begin
        int         first;
        int         guard;
        logic [3:0] v;
        int         len;

        model_reset();
        switch = 4'b1001;
        rst_n  = 1'b0;
        repeat (3) @(posedge clk_out);
        #1;
        chk_outputs();

        // Release and time the first pulse.
        #2 rst_n = 1'b1;
        first = 0;
        for (int i = 1; i <= 8; i++) begin
            step(4'b1001);
            if (cmd_valid === 1'b1 && first == 0) first = i;
        end
        chk("first_pulse_edge", 8'(first), 8'd5);

        // Single-cycle glitch must not be accepted.
        repeat (6) step(4'b0000);
        step(4'b0100);
        repeat (8) step(4'b0000);
        chk("deb_after_glitch", {4'd0, dut.u_deb.o_deb}, {4'd0, m_deb});

        // Direction change while running.
        repeat (8) step(4'b0100);
        repeat (8) step(4'b1100);
        repeat (6) step(4'b0000);

        // Illegal combination, sticky error, exit via all-zero.
        repeat (8) step(4'b0011);
        repeat (8) step(4'b0001);
        repeat (8) step(4'b0000);
        repeat (8) step(4'b0001);

        // Held combination (repeats when compiled in).
        repeat (14) step(4'b1010);
        repeat (6) step(4'b0000);

        // Random segments, including glitches and illegal vectors.
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 3))
                0:       v = {1'($urandom), 3'b000};
                1, 2:    v = {1'($urandom), 3'(1 << $urandom_range(0, 2))};
                default: v = 4'($urandom);
            endcase
            len = $urandom_range(1, 6);
            repeat (len) step(v);
        end
        repeat (6) step(4'b0000);

        // Enough combination changes to wrap step_cnt.
        for (int i = 0; i < 260; i++) begin
            repeat (DEB + 2) step((i % 2 == 0) ? 4'b0100 : 4'b1100);
        end

        // Reset while a pulse is on the output.
        guard = 0;
        while (cmd_valid !== 1'b1 && guard < 50) begin
            step((guard % 8 < 4) ? 4'b0001 : 4'b1001);
            guard++;
        end
        chk("pulse_before_reset", {7'd0, cmd_valid}, 8'd1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk_outputs();
        @(posedge clk_out);
        #2 rst_n = 1'b1;
        repeat (10) step(4'b0010);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
